// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: one-word lines, one outstanding request, refill-on-miss.
// Optional ICACHE_PERF_EN adds hit_cnt/miss_cnt performance counters.
module icache_direct_mapped #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
`ifdef ICACHE_PERF_EN
  input  logic        cache_inst_data_ok,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`else
  input  logic        cache_inst_data_ok
`endif
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [31:2]            addr_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   hit;
  logic                   fill;
  logic                   lookup_hit;
  logic                   lookup_miss;

  // Write flag, size, wdata and byte offset have no effect on a word-fetch cache.
  logic unused_inputs;
  assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

  assign idx = addr_q[INDEX_WIDTH+1:2];
  assign tag = addr_q[31:INDEX_WIDTH+2];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_addr  = {addr_q, 2'b00};
  assign cache_inst_wdata = 32'd0;

  always_comb begin
    state_nxt        = state;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = 32'd0;
    cache_inst_req   = 1'b0;
    fill             = 1'b0;
    lookup_hit       = 1'b0;
    lookup_miss      = 1'b0;
    case (state)
      IDLE: begin
        cpu_inst_addr_ok = cpu_inst_req;
        if (cpu_inst_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          lookup_hit       = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = data_mem[idx];
          state_nxt        = IDLE;
        end else begin
          lookup_miss = 1'b1;
          state_nxt   = MISS;
        end
      end
      MISS: begin
        cache_inst_req = 1'b1;
        if (cache_inst_addr_ok) begin
          // Memory may return the word in the same cycle it accepts the request.
          if (cache_inst_data_ok) begin
            fill             = 1'b1;
            cpu_inst_data_ok = 1'b1;
            cpu_inst_rdata   = cache_inst_rdata;
            state_nxt        = IDLE;
          end else begin
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        if (cache_inst_data_ok) begin
          fill             = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = cache_inst_rdata;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state <= state_nxt;
      if (cpu_inst_addr_ok) addr_q <= cpu_inst_addr[31:2];
      if (fill) valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= cache_inst_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (lookup_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (lookup_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped with a behavioural downstream memory and an rdata scoreboard.
module tb_icache_direct_mapped;

  logic        clk;
  logic        resetn;
  logic        cpu_inst_req;
  logic        cpu_inst_wr;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_wdata;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Downstream memory model controls and state
  int          ok_delay   = 0;
  int          data_delay = 0;
  bit          same_cycle = 0;
  int          mem_reqs   = 0;
  logic [31:0] last_mem_addr = 32'd0;
  int          ms;
  int          mcnt;

  icache_direct_mapped dut (
    .clk                (clk),
    .resetn             (resetn),
    .cpu_inst_req       (cpu_inst_req),
    .cpu_inst_wr        (cpu_inst_wr),
    .cpu_inst_size      (cpu_inst_size),
    .cpu_inst_addr      (cpu_inst_addr),
    .cpu_inst_wdata     (cpu_inst_wdata),
    .cpu_inst_rdata     (cpu_inst_rdata),
    .cpu_inst_addr_ok   (cpu_inst_addr_ok),
    .cpu_inst_data_ok   (cpu_inst_data_ok),
    .cache_inst_req     (cache_inst_req),
    .cache_inst_wr      (cache_inst_wr),
    .cache_inst_size    (cache_inst_size),
    .cache_inst_addr    (cache_inst_addr),
    .cache_inst_wdata   (cache_inst_wdata),
    .cache_inst_rdata   (cache_inst_rdata),
    .cache_inst_addr_ok (cache_inst_addr_ok),
`ifdef ICACHE_PERF_EN
    .cache_inst_data_ok (cache_inst_data_ok),
    .hit_cnt            (hit_cnt),
    .miss_cnt           (miss_cnt)
`else
    .cache_inst_data_ok (cache_inst_data_ok)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h3C1D_0001;
    return (a ^ 32'h5A5A_0000) + 32'h13;
  endfunction

  // ms: 0 idle, 1 accepting request, 2 returning data
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cache_inst_addr_ok <= 1'b0;
      cache_inst_data_ok <= 1'b0;
      cache_inst_rdata   <= 32'd0;
      ms                 <= 0;
      mcnt               <= 0;
    end else begin
      case (ms)
        0: if (cache_inst_req) begin
          mem_reqs      <= mem_reqs + 1;
          last_mem_addr <= cache_inst_addr;
          mcnt          <= ok_delay;
          ms            <= 1;
        end
        1: if (cache_inst_addr_ok) begin
          cache_inst_addr_ok <= 1'b0;
          cache_inst_data_ok <= 1'b0;
          mcnt               <= data_delay;
          ms                 <= cache_inst_data_ok ? 0 : 2;
        end else if (mcnt == 0) begin
          cache_inst_addr_ok <= 1'b1;
          if (same_cycle) begin
            cache_inst_data_ok <= 1'b1;
            cache_inst_rdata   <= mem_word(last_mem_addr);
          end
        end else begin
          mcnt <= mcnt - 1;
        end
        default: if (cache_inst_data_ok) begin
          cache_inst_data_ok <= 1'b0;
          ms                 <= 0;
        end else if (mcnt == 0) begin
          cache_inst_data_ok <= 1'b1;
          cache_inst_rdata   <= mem_word(last_mem_addr);
        end else begin
          mcnt <= mcnt - 1;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU fetch: push the expected word at accept, pop and compare at data_ok.
  task automatic fetch(input string tag, input logic [31:0] a, input bit wr, input bit hold,
                       output int lat, output bit no_aok, output bit stable, output int req_cyc);
    bit acc;
    bit got;
    lat = 0; no_aok = 1'b1; stable = 1'b1; req_cyc = 0; acc = 1'b0; got = 1'b0;
    @(posedge clk); #1;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = a;
    cpu_inst_wr   = wr;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (cpu_inst_addr_ok) acc = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({tag, "_accept"}, {31'd0, acc}, 32'd1);
    if (acc) begin
      exp_q.push_back(mem_word({a[31:2], 2'b00}));
      @(posedge clk); #1;
      if (!hold) cpu_inst_req = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        lat++;
        if (cpu_inst_addr_ok) no_aok = 1'b0;
        if (cache_inst_req) begin
          req_cyc++;
          if (cache_inst_addr !== {a[31:2], 2'b00}) stable = 1'b0;
        end
        if (cpu_inst_data_ok) begin
          got = 1'b1;
          check({tag, "_rdata"}, cpu_inst_rdata, exp_q.pop_front());
        end else begin
          @(posedge clk); #1;
        end
      end
      check({tag, "_data_ok_seen"}, {31'd0, got}, 32'd1);
      if (!got) exp_q.delete();
    end
    @(posedge clk); #1;
    cpu_inst_req = 1'b0;
    cpu_inst_wr  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    int lat;
    int rc;
    int base;
    bit na;
    bit st;
    bit seen;
    bit in_refill;

    resetn         = 1'b0;
    cpu_inst_req   = 1'b0;
    cpu_inst_wr    = 1'b0;
    cpu_inst_size  = 2'b10;
    cpu_inst_addr  = 32'd0;
    cpu_inst_wdata = 32'd0;
    #12;
    check("reset_addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd0);
    check("reset_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    check("reset_cache_req", {31'd0, cache_inst_req}, 32'd0);
    check("reset_rdata", cpu_inst_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Cold miss on the boot vector
    data_delay = 3;
    base = mem_reqs;
    fetch("cold", 32'h1FC0_0000, 1'b0, 1'b0, lat, na, st, rc);
    check("cold_mem_reqs", mem_reqs - base, 32'd1);
    check("cold_mem_addr", last_mem_addr, 32'h1FC0_0000);

    // Re-fetch hits with one-cycle latency
    base = mem_reqs;
    fetch("refetch", 32'h1FC0_0000, 1'b0, 1'b0, lat, na, st, rc);
    check("refetch_latency", lat, 32'd1);
    check("refetch_mem_reqs", mem_reqs - base, 32'd0);
    // Byte offset is ignored, and a write flag is treated as a read
    fetch("offset_wr", 32'h1FC0_0003, 1'b1, 1'b0, lat, na, st, rc);
    check("offset_wr_latency", lat, 32'd1);
    check("const_wr", {31'd0, cache_inst_wr}, 32'd0);
    check("const_size", {30'd0, cache_inst_size}, 32'd2);
`ifdef ICACHE_PERF_EN
    check("perf_hit_cnt", hit_cnt, 32'd2);
    check("perf_miss_cnt", miss_cnt, 32'd1);
`endif

    // Conflict eviction from a cold cache
    pulse_reset();
    data_delay = 1;
    base = mem_reqs;
    fetch("conf_a", 32'h1FC0_0000, 1'b0, 1'b0, lat, na, st, rc);
    fetch("conf_b", 32'h1FC0_0100, 1'b0, 1'b0, lat, na, st, rc);
    fetch("conf_a2", 32'h1FC0_0000, 1'b0, 1'b0, lat, na, st, rc);
    check("conflict_mem_reqs", mem_reqs - base, 32'd3);
    base = mem_reqs;
    fetch("conf_b_again", 32'h1FC0_0100, 1'b0, 1'b0, lat, na, st, rc);
    check("conflict_b_refetch_reqs", mem_reqs - base, 32'd1);

    // Downstream backpressure with the CPU request held high throughout
    ok_delay = 5;
    data_delay = 2;
    fetch("bp", 32'h0000_4A48, 1'b0, 1'b1, lat, na, st, rc);
    check("bp_addr_ok_low", {31'd0, na}, 32'd1);
    check("bp_addr_stable", {31'd0, st}, 32'd1);
    check("bp_req_held", {31'd0, rc >= 6}, 32'd1);
    ok_delay = 0;

    // Accept and data in the same cycle while in MISS
    same_cycle = 1'b1;
    fetch("same", 32'h0000_2000, 1'b0, 1'b0, lat, na, st, rc);
    check("same_latency", lat, 32'd4);
    same_cycle = 1'b0;
    fetch("same_hit", 32'h0000_2000, 1'b0, 1'b0, lat, na, st, rc);
    check("same_hit_latency", lat, 32'd1);

    // Reset while waiting for the refill word
    data_delay = 10;
    @(posedge clk); #1;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = 32'h0000_1234;
    @(negedge clk);
    check("rst_mid_accept", {31'd0, cpu_inst_addr_ok}, 32'd1);
    @(posedge clk); #1;
    cpu_inst_req = 1'b0;
    seen = 1'b0;
    in_refill = 1'b0;
    for (int i = 0; i < 30 && !in_refill; i++) begin
      @(negedge clk);
      if (cache_inst_req) seen = 1'b1;
      else if (seen) in_refill = 1'b1;
    end
    check("rst_mid_reached_refill", {31'd0, in_refill}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    check("rst_mid_cache_req", {31'd0, cache_inst_req}, 32'd0);
    check("rst_mid_rdata", cpu_inst_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    data_delay = 1;
    base = mem_reqs;
    fetch("rst_refetch", 32'h0000_1234, 1'b0, 1'b0, lat, na, st, rc);
    check("rst_refetch_reqs", mem_reqs - base, 32'd1);
    base = mem_reqs;
    fetch("rst_valid_cleared", 32'h0000_2000, 1'b0, 1'b0, lat, na, st, rc);
    check("rst_valid_cleared_reqs", mem_reqs - base, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
